qc_rotator_pipe: RTL and testbench
==================================

Name: qc_rotator_pipe

Overview:
- Fully pipelined, runtime-configurable circular rotator for the QC-LDPC datapath.
- Rotates the low Z bits of a MAXZ-wide word by a per-beat shift value. Z is selectable per beat, which supports multiple lifting sizes (e.g. 802.11n Z=27/54/81, 5G NR up to 384).
- Adds valid/ready flow control, a direction select and a passthrough tag.
- Sits between the message/LLR memories and the check-node units.

Parameters:
- MAXZ, 384, maximum lifting size and data width in bits.
- LAT, 4, pipeline latency in cycles (register stages); legal range 1..$clog2(MAXZ).
- TAG_W, 8, width of sideband tag carried alongside data.

Ports:
- CLK  input  1  clock
- rst_n  input  1  reset
- in_valid  input  1  input beat valid
- in_ready  output  1  rotator can accept beat
- in_data  input  MAXZ  data; bits [MAXZ-1:in_z] ignored
- in_z  input  $clog2(MAXZ+1)  active lifting size Z for this beat
- in_shift  input  $clog2(MAXZ)  rotation amount s
- in_dir  input  1  0 = down-rotate, 1 = up-rotate
- in_tag  input  TAG_W  sideband, returned unchanged
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts beat
- out_data  output  MAXZ  rotated data
- out_tag  output  TAG_W  tag of this beat
- out_err  output  1  illegal-parameter flag (see Optional Feature)

Behaviour:
- Interface decision: reset rst_n, synchronous, active-low; clock CLK.
- Reset: all stage valids cleared. out_valid=0, out_data=0, out_tag=0, out_err=0. in_ready=1 in the first cycle after reset deasserts.
- Reset mid-operation: all in-flight beats are discarded, never emitted.
- Transfer rule: a beat transfers on a CLK edge with valid&&ready high on that side.
- Rotation, for 0 <= j < Z:
  - in_dir=0: out_data[j] = in_data[(j+s) mod Z]
  - in_dir=1: out_data[j] = in_data[(j-s) mod Z]
- Bits out_data[MAXZ-1:Z] are 0.
- s=0 passes data through, with bits at or above Z zeroed.
- Z, s, dir and tag are captured per beat. Consecutive beats may use different Z and direction with no bubble.
- Latency: exactly LAT cycles from input transfer to out_valid, with out_ready held high.
- Throughput: one beat per cycle.
- Flow control is a global stall:
  - in_ready = out_ready || !out_valid.
  - When out_valid && !out_ready, every stage holds and out_data/out_tag/out_err stay stable.
- Bubbles: stages with valid=0 may advance during a stall (bubble collapse is permitted but not required). Beat order is always preserved.
- Simultaneous input accept and output drain in one cycle is supported, with no loss or duplication.
- Data registers need no reset; valid registers must be reset. Outputs must still read 0 after reset until the first valid beat (output register reset or gated).

Optional Feature:
- Macro: QC_ROTATOR_ERR_CHECK_EN.
- Defined: a beat is illegal when in_z==0, in_z>MAXZ or in_shift>=in_z.
  - The illegal beat still flows with normal latency and tag.
  - out_err=1 for that beat; out_data=0.
  - Legal beats have out_err=0.
- Undefined: out_err is tied to 0. out_data for illegal beats is unspecified; the bench must not check it.

Test Plan:
- Latency/passthrough (MAXZ=384, LAT=4): Z=384, s=0, data=0xA5 pattern, tag=0x11 → out_valid exactly 4 cycles later, data identical, tag=0x11.
- Small-Z down-rotate: Z=27, s=1, dir=0, in_data=1<<0 → out bit 26 set only. Same input with dir=1 → out bit 1 set only. Bits 27+ of input set to all ones → output bits 27+ are 0.
- Back-to-back mixed beats (Z=81/s=80, Z=54/s=3, Z=384/s=383), one per cycle → three consecutive output beats, each matching the reference model, in order.
- Backpressure: stream 10 random beats, drop out_ready for 3 cycles mid-stream → in_ready low while output is stalled, output held stable, all 10 beats delivered once, in order.
- Reset mid-flight: assert rst_n=0 for 1 cycle with 3 beats in the pipe → out_valid=0, out_data=0, and none of the 3 beats ever emerges.
- With QC_ROTATOR_ERR_CHECK_EN: Z=27, s=27 → out_err=1, out_data=0 after LAT. Following beat Z=27, s=26 → out_err=0 with correct data.

Source files
------------

// File: rtl/qc_rotator_pipe_if.sv
// Bus bundle for qc_rotator_pipe: input beat channel and rotated output channel.
// A beat moves on a rising CLK edge when valid && ready are both high on that side; valid never waits on ready.
interface qc_rotator_pipe_if #(
    parameter int MAXZ  = 384,
    parameter int TAG_W = 8
);
    localparam int ZW = $clog2(MAXZ + 1);
    localparam int SW = $clog2(MAXZ);

    logic             in_valid;
    logic             in_ready;
    logic [MAXZ-1:0]  in_data;
    logic [ZW-1:0]    in_z;
    logic [SW-1:0]    in_shift;
    logic             in_dir;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [MAXZ-1:0]  out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    modport master (
        output in_valid, in_data, in_z, in_shift, in_dir, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_data, in_z, in_shift, in_dir, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_err
    );
endinterface

// File: rtl/qc_rotator_pipe.sv
// Pipelined circular rotator over the low Z bits of a MAXZ-wide word, Z chosen per beat.
// Optional illegal-beat flagging is enabled with `define QC_ROTATOR_ERR_CHECK_EN.
module qc_rotator_pipe #(
    parameter int MAXZ  = 384,
    parameter int LAT   = 4,
    parameter int TAG_W = 8
) (
    input logic                CLK,
    input logic                rst_n,
    qc_rotator_pipe_if.slave   bus
);
    localparam int ZW   = $clog2(MAXZ + 1);
    localparam int SW   = $clog2(MAXZ);
    localparam int NLEV = SW;
    localparam int DW   = 2 * MAXZ;

    // Barrel levels are spread evenly across the LAT register stages.
    function automatic logic [DW-1:0] rot_levels(input logic [DW-1:0] d,
                                                 input logic [SW-1:0] e,
                                                 input int stage);
        logic [DW-1:0] r;
        r = d;
        for (int l = 0; l < NLEV; l++) begin
            if (((l * LAT) / NLEV) == stage && e[l]) r = r >> (1 << l);
        end
        return r;
    endfunction

    function automatic logic [MAXZ-1:0] z_mask(input logic [ZW-1:0] z);
        logic [MAXZ-1:0] m;
        m = '0;
        for (int j = 0; j < MAXZ; j++) m[j] = (j < int'(z));
        return m;
    endfunction

    logic                adv;
    logic [MAXZ-1:0]     pre_masked;
    logic [DW-1:0]       pre_dbl;
    logic [SW-1:0]       pre_shift;
    logic                pre_err;

    logic [LAT-1:0]      st_valid;
    logic [DW-1:0]       st_data  [LAT];
    logic [SW-1:0]       st_shift [LAT];
    logic [ZW-1:0]       st_z     [LAT];
    logic [TAG_W-1:0]    st_tag   [LAT];
    logic                st_err   [LAT];

    logic [LAT-1:0]      src_valid;
    logic [DW-1:0]       src_data  [LAT];
    logic [SW-1:0]       src_shift [LAT];
    logic [ZW-1:0]       src_z     [LAT];
    logic [TAG_W-1:0]    src_tag   [LAT];
    logic                src_err   [LAT];

    assign bus.out_valid = st_valid[LAT-1];
    assign adv           = bus.out_ready || !st_valid[LAT-1];
    assign bus.in_ready  = adv;

    // Duplicating the Z-bit word above itself turns the modulo-Z rotation into a plain right shift.
    // An up-rotate by s is the same as a down-rotate by Z-s.
    always_comb begin
        pre_masked = bus.in_data & z_mask(bus.in_z);
        pre_dbl    = {{MAXZ{1'b0}}, pre_masked} | ({{MAXZ{1'b0}}, pre_masked} << bus.in_z);
        pre_shift  = bus.in_shift;
        if (bus.in_dir && bus.in_shift != '0) pre_shift = SW'(bus.in_z - ZW'(bus.in_shift));
    end

`ifdef QC_ROTATOR_ERR_CHECK_EN
    assign pre_err = (bus.in_z == '0) || (bus.in_z > ZW'(MAXZ)) || (ZW'(bus.in_shift) >= bus.in_z);
`else
    assign pre_err = 1'b0;
`endif

    always_comb begin
        src_valid[0] = bus.in_valid;
        src_data[0]  = pre_dbl;
        src_shift[0] = pre_shift;
        src_z[0]     = bus.in_z;
        src_tag[0]   = bus.in_tag;
        src_err[0]   = pre_err;
        for (int i = 1; i < LAT; i++) begin
            src_valid[i] = st_valid[i-1];
            src_data[i]  = st_data[i-1];
            src_shift[i] = st_shift[i-1];
            src_z[i]     = st_z[i-1];
            src_tag[i]   = st_tag[i-1];
            src_err[i]   = st_err[i-1];
        end
    end

    // A single global enable: the whole pipe advances or the whole pipe holds.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            st_valid <= '0;
        end else if (adv) begin
            st_valid <= src_valid;
        end
    end

    always_ff @(posedge CLK) begin
        if (adv) begin
            for (int i = 0; i < LAT; i++) begin
                st_data[i]  <= rot_levels(src_data[i], src_shift[i], i);
                st_shift[i] <= src_shift[i];
                st_z[i]     <= src_z[i];
                st_tag[i]   <= src_tag[i];
                st_err[i]   <= src_err[i];
            end
        end
    end

    // Outputs read zero whenever no beat is presented, including straight after reset.
    always_comb begin
        bus.out_data = '0;
        bus.out_tag  = '0;
        bus.out_err  = 1'b0;
        if (st_valid[LAT-1]) begin
            bus.out_tag = st_tag[LAT-1];
            bus.out_err = st_err[LAT-1];
            if (!st_err[LAT-1]) bus.out_data = st_data[LAT-1][MAXZ-1:0] & z_mask(st_z[LAT-1]);
        end
    end
endmodule

// File: tb/tb_qc_rotator_pipe.sv
// Self-checking bench for qc_rotator_pipe: directed cases plus randomized beats with random backpressure.
module tb_qc_rotator_pipe;
  localparam int MAXZ  = 384;
  localparam int LAT   = 4;
  localparam int TAG_W = 8;
  localparam int ZW    = $clog2(MAXZ + 1);
  localparam int SW    = $clog2(MAXZ);
  localparam int W     = MAXZ + TAG_W + 1;

  // clock / reset
  logic CLK = 1'b0;
  logic rst_n = 1'b0;
  always #5 CLK = ~CLK;

  qc_rotator_pipe_if #(.MAXZ(MAXZ), .TAG_W(TAG_W)) bus ();

  qc_rotator_pipe #(.MAXZ(MAXZ), .LAT(LAT), .TAG_W(TAG_W)) dut (
    .CLK  (CLK),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_lat = 1'b1;
  bit stream_done = 1'b0;
  logic [W-1:0] exp_q[$];
  int acc_q[$];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: bit j of the result takes bit (j+s) mod Z (down) or (j-s) mod Z (up).
  function automatic logic [W-1:0] model(input logic [MAXZ-1:0] d, input int z, input int s,
                                         input bit dir, input logic [TAG_W-1:0] tag);
    logic [MAXZ-1:0] r;
    bit e;
    int idx;
    r = '0;
    e = 1'b0;
`ifdef QC_ROTATOR_ERR_CHECK_EN
    e = (z == 0) || (z > MAXZ) || (s >= z);
`endif
    if (!e) begin
      for (int j = 0; j < z; j++) begin
        if (dir) idx = (((j - s) % z) + z) % z;
        else     idx = (j + s) % z;
        r[j] = d[idx];
      end
    end
    return {e, tag, r};
  endfunction

  function automatic logic [MAXZ-1:0] rand_data();
    logic [MAXZ-1:0] r;
    for (int k = 0; k < MAXZ; k += 32) r[k +: 32] = $urandom;
    return r;
  endfunction

  // scoreboard / monitor
  initial begin
    logic prev_stall;
    logic [W-1:0] prev_word;
    logic [W-1:0] word;
    logic [W-1:0] e;
    int a;
    prev_stall = 1'b0;
    prev_word = '0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        word = {bus.out_err, bus.out_tag, bus.out_data};
        if (prev_stall) check("hold_during_stall", word, prev_word);
        if (bus.out_valid && !bus.out_ready) check("in_ready_stall", W'(bus.in_ready), W'(0));
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", W'(1), W'(0));
          end else begin
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            check("beat", word, e);
            if (chk_lat) check("latency", W'(cyc - a), W'(LAT));
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          exp_q.push_back(model(bus.in_data, int'(bus.in_z), int'(bus.in_shift), bus.in_dir, bus.in_tag));
          acc_q.push_back(cyc);
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_word = word;
      end
    end
  end

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic send(input logic [MAXZ-1:0] d, input int z, input int s, input bit dir,
                      input logic [TAG_W-1:0] tag);
    int budget;
    bit acc;
    budget = 0;
    bus.in_data  = d;
    bus.in_z     = ZW'(z);
    bus.in_shift = SW'(s);
    bus.in_dir   = dir;
    bus.in_tag   = tag;
    bus.in_valid = 1'b1;
    do begin
      @(negedge CLK);
      acc = bus.in_ready;
      @(posedge CLK);
      #1;
      budget++;
    end while (!acc && budget < 200);
    if (!acc) check("send_timeout", W'(0), W'(1));
  endtask

  task automatic send_random();
    int z;
    int s;
    z = $urandom_range(1, MAXZ);
    s = $urandom_range(0, z - 1);
`ifdef QC_ROTATOR_ERR_CHECK_EN
    if ($urandom_range(0, 7) == 0) s = $urandom_range(z, (1 << SW) - 1);
`endif
    send(rand_data(), z, s, 1'($urandom_range(0, 1)), TAG_W'($urandom));
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && exp_q.size() > 0; k++) cycles(1);
    check("drain_empty", W'(exp_q.size()), W'(0));
  endtask

  initial begin
    logic [MAXZ-1:0] d;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_z      = '0;
    bus.in_shift  = '0;
    bus.in_dir    = 1'b0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    cycles(3);
    rst_n = 1'b1;

    @(negedge CLK);
    check("rst_out_valid", W'(bus.out_valid), W'(0));
    check("rst_out_data", W'(bus.out_data), W'(0));
    check("rst_out_tag", W'(bus.out_tag), W'(0));
    check("rst_out_err", W'(bus.out_err), W'(0));
    check("rst_in_ready", W'(bus.in_ready), W'(1));
    @(posedge CLK);
    #1;

    // passthrough at full width
    d = {(MAXZ / 8){8'hA5}};
    send(d, MAXZ, 0, 1'b0, 8'h11);
    idle();
    cycles(LAT + 4);

    // small Z, single bit, both directions, junk above Z
    d = '0;
    d[0] = 1'b1;
    send(d, 27, 1, 1'b0, 8'h21);
    send(d, 27, 1, 1'b1, 8'h22);
    d = '1;
    d[26:0] = 27'h1;
    send(d, 27, 1, 1'b0, 8'h23);
    idle();
    cycles(LAT + 4);

    // back-to-back mixed Z
    send(rand_data(), 81, 80, 1'b0, 8'h31);
    send(rand_data(), 54, 3, 1'b1, 8'h32);
    send(rand_data(), 384, 383, 1'b0, 8'h33);
    idle();
    cycles(LAT + 4);

    // backpressure mid-stream
    chk_lat = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) send_random();
        idle();
      end
      begin
        cycles(5);
        bus.out_ready = 1'b0;
        cycles(3);
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk_lat = 1'b1;

    // reset with beats in flight
    for (int i = 0; i < 3; i++) send_random();
    idle();
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    cycles(1);
    rst_n = 1'b1;
    @(negedge CLK);
    check("midrst_out_valid", W'(bus.out_valid), W'(0));
    check("midrst_out_data", W'(bus.out_data), W'(0));
    cycles(LAT + 6);

`ifdef QC_ROTATOR_ERR_CHECK_EN
    send(rand_data(), 27, 27, 1'b0, 8'h5A);
    send(rand_data(), 27, 26, 1'b0, 8'h5B);
    send(rand_data(), 0, 0, 1'b1, 8'h5C);
    send(rand_data(), 400, 5, 1'b0, 8'h5D);
    idle();
    cycles(LAT + 4);
`endif

    // random traffic with random gaps and random backpressure
    chk_lat = 1'b0;
    stream_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            idle();
            cycles($urandom_range(1, 2));
          end
          send_random();
        end
        idle();
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
          cycles(1);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
